// File: rtl/csd_shift_add_mult_if.sv
// ---------------------------------------------------------------------------
// csd_shift_add_mult_if
//   Groups the operand, digit-stream and product signals of the CSD
//   shift-add multiplier.
//   master : producer/consumer side (drives start, x, digits, p_ready)
//   slave  : multiplier side (drives din_ready, p_valid, product, nz_cnt, err)
//   Signals:
//     start      one-cycle pulse that launches an operation
//     x          signed multiplicand, captured with start
//     din_*      CSD digit stream, LSB first, valid/ready handshake
//     p_valid    product available
//     p_ready    consumer accepts the product
//     product    signed result, W+N bits
//     nz_cnt     number of nonzero digits applied
//     err        sticky per-operation error flag
// ---------------------------------------------------------------------------
interface csd_shift_add_mult_if #(
  parameter int W = 8,
  parameter int N = 9,
  parameter int P = W + N
);
  localparam int CW = $clog2(N + 1);

  logic          start;
  logic [W-1:0]  x;
  logic          din_valid;
  logic          din_ready;
  logic [1:0]    din_digit;
  logic          din_last;
  logic          p_valid;
  logic          p_ready;
  logic [P-1:0]  product;
  logic [CW-1:0] nz_cnt;
  logic          err;

  modport master (
    output start, x, din_valid, din_digit, din_last, p_ready,
    input  din_ready, p_valid, product, nz_cnt, err
  );

  modport slave (
    input  start, x, din_valid, din_digit, din_last, p_ready,
    output din_ready, p_valid, product, nz_cnt, err
  );
endinterface

// File: rtl/csd_shift_add_mult.sv
// ---------------------------------------------------------------------------
// csd_shift_add_mult
//   Multiplies a signed multiplicand by a canonical-signed-digit stream
//   delivered LSB first. Each accepted digit adds, subtracts or skips the
//   progressively left-shifted multiplicand. Illegal digit codes, adjacent
//   nonzero digits and streams longer than N digits set a sticky error.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset, clears all state
//     bus    csd_shift_add_mult_if.slave (operand, digits, product, status)
// ---------------------------------------------------------------------------
module csd_shift_add_mult #(
  parameter int W = 8,
  parameter int N = 9,
  parameter int P = W + N
) (
  input logic                  clk,
  input logic                  rst_n,
  csd_shift_add_mult_if.slave  bus
);

  localparam int CW = $clog2(N + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q, state_d;
  logic signed [P-1:0]   mcand_q;
  logic signed [P-1:0]   acc_q;
  logic [IW-1:0]         idx_q;
  logic [CW-1:0]         nz_q;
  logic                  err_q;
  logic                  prev_nz_q;

  logic accept;
  logic dig_pos;
  logic dig_neg;
  logic dig_bad;
  logic dig_nz;
  logic overrun;

  assign accept  = (state_q == RUN) && bus.din_valid;
  assign dig_pos = (bus.din_digit == 2'b01);
  assign dig_neg = (bus.din_digit == 2'b11);
  assign dig_bad = (bus.din_digit == 2'b10);
  assign dig_nz  = dig_pos || dig_neg;
  // A full-length stream without a last marker is closed off here.
  assign overrun = (idx_q == IW'(N - 1)) && !bus.din_last;

  // State register.
  // NOTE: every register, including the datapath, sits on the async reset so
  // an aborted operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (accept && (bus.din_last || overrun)) state_d = DONE;
      DONE:    if (bus.p_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: results stay on the bus until the next start clears them.
  always_comb begin
    bus.din_ready = (state_q == RUN);
    bus.p_valid   = (state_q == DONE);
    bus.product   = acc_q;
    bus.nz_cnt    = nz_q;
    bus.err       = err_q;
  end

  // Datapath.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      nz_q      <= '0;
      err_q     <= 1'b0;
      prev_nz_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start) begin
          mcand_q   <= {{(P-W){bus.x[W-1]}}, bus.x};
          acc_q     <= '0;
          idx_q     <= '0;
          nz_q      <= '0;
          err_q     <= 1'b0;
          prev_nz_q <= 1'b0;
        end
        RUN: if (accept) begin
          if (dig_pos)      acc_q <= acc_q + mcand_q;
          else if (dig_neg) acc_q <= acc_q - mcand_q;
          if (dig_nz) nz_q <= nz_q + CW'(1);
          // Sticky: illegal code, two nonzero digits in a row, or overrun.
          if (dig_bad || (dig_nz && prev_nz_q) || overrun) err_q <= 1'b1;
          prev_nz_q <= dig_nz;
          mcand_q   <= mcand_q <<< 1;
          idx_q     <= idx_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csd_shift_add_mult.sv
// ---------------------------------------------------------------------------
// tb_csd_shift_add_mult
//   Self-checking bench for csd_shift_add_mult. Expected results come from an
//   integer model of the digit stream and are queued at operation start, then
//   popped and compared when the product appears.
// ---------------------------------------------------------------------------
module tb_csd_shift_add_mult;

  localparam int W = 8;
  localparam int N = 9;

  typedef struct {
    longint product;
    int     nz;
    int     err;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  logic [1:0] dq[$];
  int n_checks;
  int n_fail;

  csd_shift_add_mult_if #(.W(W), .N(N)) bus ();

  csd_shift_add_mult #(.W(W), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic signed [W-1:0] xv);
    bus.start = 1'b1;
    bus.x     = xv;
    tick();
    bus.start = 1'b0;
    check("run_entry", bus.din_ready, 1);
  endtask

  task automatic send_digit(input logic [1:0] d, input logic last);
    int n;
    n = 0;
    bus.din_valid = 1'b1;
    bus.din_digit = d;
    bus.din_last  = last;
    while (!bus.din_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) check("accept_timeout", 0, 1);
    else         tick();
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
  endtask

  // Runs one operation from the digits in dq. mark_last places din_last on
  // the final digit; gap_len idle cycles (with stray start pulses) are
  // inserted before digit gap_idx; hold delays p_ready.
  task automatic run_op(input string tag, input logic signed [W-1:0] xv,
                        input bit mark_last, input int gap_idx,
                        input int gap_len, input int hold);
    longint acc;
    int     nz, e, waited;
    bit     prev;
    exp_t   ex, got;
    acc = 0; nz = 0; e = 0; prev = 0;
    foreach (dq[i]) begin
      case (dq[i])
        2'b01: begin acc += longint'(xv) <<< i; nz++; if (prev) e = 1; prev = 1; end
        2'b11: begin acc -= longint'(xv) <<< i; nz++; if (prev) e = 1; prev = 1; end
        2'b10: begin e = 1; prev = 0; end
        default: prev = 0;
      endcase
    end
    if (!mark_last) e = 1;
    ex.product = acc; ex.nz = nz; ex.err = e;
    sb.push_back(ex);

    do_start(xv);
    foreach (dq[i]) begin
      if (i == gap_idx) begin
        for (int k = 0; k < gap_len; k++) begin
          bus.start = 1'b1;
          bus.x     = 8'sd99;
          tick();
        end
        bus.start = 1'b0;
      end
      send_digit(dq[i], mark_last && (i == dq.size() - 1));
    end

    waited = 0;
    while (!bus.p_valid && waited < 30) begin
      tick();
      waited++;
    end
    check({tag, "_latency"}, waited, 0);
    got = sb.pop_front();
    check({tag, "_product"}, $signed(bus.product), got.product);
    check({tag, "_nz_cnt"}, bus.nz_cnt, got.nz);
    check({tag, "_err"}, bus.err, got.err);
    check({tag, "_din_ready"}, bus.din_ready, 0);

    bus.p_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold_valid"}, bus.p_valid, 1);
      check({tag, "_hold_product"}, $signed(bus.product), got.product);
    end
    bus.p_ready = 1'b1;
    tick();
    bus.p_ready = 1'b0;
    check({tag, "_p_valid_drop"}, bus.p_valid, 0);
    check({tag, "_idle_ready"}, bus.din_ready, 0);
    check({tag, "_product_kept"}, $signed(bus.product), got.product);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.x         = '0;
    bus.din_valid = 1'b0;
    bus.din_digit = 2'b00;
    bus.din_last  = 1'b0;
    bus.p_ready   = 1'b0;
    repeat (2) tick();
    check("rst_din_ready", bus.din_ready, 0);
    check("rst_p_valid", bus.p_valid, 0);
    check("rst_product", bus.product, 0);
    check("rst_nz_cnt", bus.nz_cnt, 0);
    check("rst_err", bus.err, 0);
    rst_n = 1'b1;
    tick();

    // din_valid ignored in IDLE
    bus.din_valid = 1'b1;
    bus.din_digit = 2'b01;
    tick();
    bus.din_valid = 1'b0;
    check("idle_ignore", bus.din_ready, 0);

    dq = {2'b11, 2'b00, 2'b00, 2'b01};
    run_op("x13", 8'sd13, 1'b1, -1, 0, 0);

    dq = {2'b11, 2'b00, 2'b00, 2'b00, 2'b01};
    run_op("xm5", -8'sd5, 1'b1, -1, 0, 5);

    dq = {2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    run_op("xm128", -8'sd128, 1'b1, -1, 0, 0);
    run_op("xm128_overrun", -8'sd128, 1'b0, -1, 0, 0);

    dq = {2'b01, 2'b01};
    run_op("x7_adj", 8'sd7, 1'b1, -1, 0, 0);

    dq = {2'b01, 2'b10, 2'b01};
    run_op("x7_illegal", 8'sd7, 1'b1, -1, 0, 0);

    dq = {2'b00, 2'b01};
    run_op("x3_gap", 8'sd3, 1'b1, 1, 2, 1);

    dq = {2'b11, 2'b00, 2'b01};
    run_op("xm1", -8'sd1, 1'b1, -1, 0, 0);

    // Mid-stream reset aborts the operation.
    do_start(8'sd9);
    send_digit(2'b01, 1'b0);
    send_digit(2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_din_ready", bus.din_ready, 0);
    check("mid_rst_p_valid", bus.p_valid, 0);
    check("mid_rst_product", bus.product, 0);
    check("mid_rst_nz_cnt", bus.nz_cnt, 0);
    check("mid_rst_err", bus.err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    dq = {2'b01};
    run_op("x1_after_rst", 8'sd1, 1'b1, -1, 0, 0);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
